// File: rtl/term_line_editor.sv
// term_line_editor
// Line editor for the display terminal. Parses a UART byte stream (printable
// ASCII, BS/DEL, CR, ESC [ C/D/H/F, ESC [ 3 ~) into an NPOS-character display
// buffer with a cursor, and hands each completed line to a downstream consumer.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   in_valid/in_data/in_ready   input byte stream (accepted on valid&&ready)
//   ins_mode        1=insert, 0=overwrite; sampled with each printable byte
//   disp            display buffer, position i at [8i+7:8i], position 0 leftmost
//   cursor          current cursor position
//   line_valid/line_data/line_ready   completed-line handshake
//   seq_err         one-cycle pulse when an escape sequence is abandoned
module term_line_editor #(
  parameter int NPOS   = 4,
  parameter int ESC_TO = 1023,
  parameter int CURW   = $clog2(NPOS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  input  logic                ins_mode,
  output logic [8*NPOS-1:0]   disp,
  output logic [CURW-1:0]     cursor,
  output logic                line_valid,
  output logic [8*NPOS-1:0]   line_data,
  input  logic                line_ready,
  output logic                seq_err
);

  localparam int TOW = $clog2(ESC_TO + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ESC, ST_CSI, ST_CSI3} state_t;
  typedef logic [NPOS-1:0][7:0] buf_t;

  localparam buf_t            BLANK   = {NPOS{8'h20}};
  localparam logic [CURW-1:0] CUR_MAX = CURW'(NPOS - 1);
  // Last count before expiry: the abort fires on the edge the count would reach ESC_TO.
  localparam logic [TOW-1:0]  TO_LAST = TOW'(ESC_TO - 1);

  state_t          state_q, state_d;
  buf_t            disp_q, disp_d;
  logic [CURW-1:0] cursor_q, cursor_d;
  logic            line_valid_q, line_valid_d;
  buf_t            line_data_q, line_data_d;
  logic            seq_err_q, seq_err_d;
  logic [TOW-1:0]  to_cnt_q, to_cnt_d;
  logic            accept_s;

  // Insert ch at p: p..NPOS-2 move right one place, the last character falls off.
  function automatic buf_t ins_at(input buf_t b, input logic [CURW-1:0] p,
                                  input logic [7:0] ch);
    buf_t shr;
    buf_t r;
    shr = {b[NPOS-2:0], 8'h20};
    for (int i = 0; i < NPOS; i++) begin
      if (CURW'(i) > p) r[i] = shr[i];
      else if (CURW'(i) == p) r[i] = ch;
      else r[i] = b[i];
    end
    return r;
  endfunction

  // Overwrite position p with ch.
  function automatic buf_t ovr_at(input buf_t b, input logic [CURW-1:0] p,
                                  input logic [7:0] ch);
    buf_t r;
    r    = b;
    r[p] = ch;
    return r;
  endfunction

  // Delete at p: p+1..NPOS-1 move left one place, a space fills the end.
  function automatic buf_t del_at(input buf_t b, input logic [CURW-1:0] p);
    buf_t shl;
    buf_t r;
    shl = {8'h20, b[NPOS-1:1]};
    for (int i = 0; i < NPOS; i++) begin
      if (CURW'(i) >= p) r[i] = shl[i];
      else r[i] = b[i];
    end
    return r;
  endfunction

  // Input is only back-pressured while a finished line waits for the consumer.
  assign in_ready = ~(line_valid_q & ~line_ready);
  assign accept_s = in_valid & in_ready;

  assign disp       = disp_q;
  assign cursor     = cursor_q;
  assign line_valid = line_valid_q;
  assign line_data  = line_data_q;
  assign seq_err    = seq_err_q;

  // Parser next-state, buffer edits, line hand-off and escape timeout.
  always_comb begin
    state_d     = state_q;
    disp_d      = disp_q;
    cursor_d    = cursor_q;
    line_data_d = line_data_q;
    seq_err_d   = 1'b0;
    to_cnt_d    = to_cnt_q;
    if (line_valid_q && line_ready) line_valid_d = 1'b0;
    else line_valid_d = line_valid_q;

    if (accept_s) begin
      // An accepted byte always restarts the timeout, even in the expiry cycle.
      to_cnt_d = {TOW{1'b0}};
      case (state_q)
        ST_IDLE: begin
          if (in_data == 8'h1B) begin
            state_d = ST_ESC;
          end else if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            if (ins_mode) disp_d = ins_at(disp_q, cursor_q, in_data);
            else disp_d = ovr_at(disp_q, cursor_q, in_data);
            if (cursor_q != CUR_MAX) cursor_d = cursor_q + 1'b1;
            else cursor_d = cursor_q;
          end else if (in_data == 8'h08 || in_data == 8'h7F) begin
            if (cursor_q != {CURW{1'b0}}) begin
              cursor_d = cursor_q - 1'b1;
              disp_d   = del_at(disp_q, cursor_q - 1'b1);
            end else begin
              cursor_d = cursor_q;
            end
          end else if (in_data == 8'h0D) begin
            line_data_d  = disp_q;
            line_valid_d = 1'b1;
            disp_d       = BLANK;
            cursor_d     = {CURW{1'b0}};
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ESC: begin
          if (in_data == 8'h5B) begin
            state_d = ST_CSI;
          end else if (in_data == 8'h1B) begin
            state_d = ST_ESC;
          end else begin
            state_d   = ST_IDLE;
            seq_err_d = 1'b1;
          end
        end
        ST_CSI: begin
          case (in_data)
            8'h43: begin
              state_d = ST_IDLE;
              if (cursor_q != CUR_MAX) cursor_d = cursor_q + 1'b1;
              else cursor_d = cursor_q;
            end
            8'h44: begin
              state_d = ST_IDLE;
              if (cursor_q != {CURW{1'b0}}) cursor_d = cursor_q - 1'b1;
              else cursor_d = cursor_q;
            end
            8'h48: begin
              state_d  = ST_IDLE;
              cursor_d = {CURW{1'b0}};
            end
            8'h46: begin
              state_d  = ST_IDLE;
              cursor_d = CUR_MAX;
            end
            8'h33: state_d = ST_CSI3;
            8'h1B: state_d = ST_ESC;
            default: begin
              state_d   = ST_IDLE;
              seq_err_d = 1'b1;
            end
          endcase
        end
        ST_CSI3: begin
          if (in_data == 8'h7E) begin
            state_d = ST_IDLE;
            disp_d  = del_at(disp_q, cursor_q);
          end else if (in_data == 8'h1B) begin
            state_d = ST_ESC;
          end else begin
            state_d   = ST_IDLE;
            seq_err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (to_cnt_q == TO_LAST) begin
        state_d   = ST_IDLE;
        seq_err_d = 1'b1;
        to_cnt_d  = {TOW{1'b0}};
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end else begin
      to_cnt_d = {TOW{1'b0}};
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      disp_q       <= BLANK;
      cursor_q     <= {CURW{1'b0}};
      line_valid_q <= 1'b0;
      line_data_q  <= BLANK;
      seq_err_q    <= 1'b0;
      to_cnt_q     <= {TOW{1'b0}};
    end else begin
      state_q      <= state_d;
      disp_q       <= disp_d;
      cursor_q     <= cursor_d;
      line_valid_q <= line_valid_d;
      line_data_q  <= line_data_d;
      seq_err_q    <= seq_err_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

endmodule

// File: tb/tb_term_line_editor.sv
module tb_term_line_editor;
  localparam int NPOS   = 4;
  localparam int ESC_TO = 16;
  localparam logic [7:0] ESC = 8'h1B;
  localparam logic [7:0] CR  = 8'h0D;
  localparam logic [7:0] BS  = 8'h08;
  localparam logic [7:0] DEL = 8'h7F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        ins_mode = 1'b0;
  logic [31:0] disp;
  logic [1:0]  cursor;
  logic        line_valid;
  logic [31:0] line_data;
  logic        line_ready = 1'b1;
  logic        seq_err;

  typedef struct packed { logic [31:0] d; logic [1:0] c; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] line_q[$];
  int          err_q[$];
  int checks = 0;
  int errors = 0;

  term_line_editor #(.NPOS(NPOS), .ESC_TO(ESC_TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ins_mode(ins_mode), .disp(disp), .cursor(cursor),
    .line_valid(line_valid), .line_data(line_data), .line_ready(line_ready),
    .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] s2b(input string s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  // Send one byte; the expected disp/cursor after it is queued for the monitor.
  task automatic tx(input logic [7:0] b, input string d, input int c);
    int n;
    exp_t e;
    e.d = s2b(d);
    e.c = 2'(c);
    exp_q.push_back(e);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL tx_accept: byte %h never accepted", b);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic tx_err(input logic [7:0] b, input string d, input int c);
    err_q.push_back(1);
    tx(b, d, c);
  endtask

  // Let the monitor consume the last byte's effect.
  task automatic settle();
    @(negedge clk); #1;
  endtask

  // Monitor: compares every DUT-presented event against the queued expectations.
  initial begin
    logic pend;
    exp_t e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL byte_update: got disp %h with no expectation", disp);
          end else begin
            e = exp_q.pop_front();
            chk("disp", 64'(disp), 64'(e.d));
            chk("cursor", 64'(cursor), 64'(e.c));
          end
        end
        pend = in_valid && in_ready;
        if (line_valid && line_ready) begin
          if (line_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL line_out: got unexpected line %h expected none", line_data);
          end else begin
            chk("line_data", 64'(line_data), 64'(line_q.pop_front()));
          end
        end
        if (seq_err) begin
          checks++;
          if (err_q.size() == 0) begin
            errors++;
            $display("FAIL seq_err: got pulse expected none");
          end else begin
            void'(err_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    #12 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_disp", 64'(disp), 64'(s2b("    ")));
    chk("rst_cursor", 64'(cursor), 64'd0);
    chk("rst_line_valid", 64'(line_valid), 64'd0);
    chk("rst_line_data", 64'(line_data), 64'(s2b("    ")));
    chk("rst_seq_err", 64'(seq_err), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Overwrite with cursor-left
    tx("A", "A   ", 1); tx("B", "AB  ", 2);
    tx(ESC, "AB  ", 2); tx("[", "AB  ", 2); tx("D", "AB  ", 1);
    tx("X", "AX  ", 2);
    line_q.push_back(s2b("AX  "));
    tx(CR, "    ", 0);

    // Insert mode, home, saturation
    ins_mode = 1'b1;
    tx("A", "A   ", 1); tx("B", "AB  ", 2); tx("C", "ABC ", 3); tx("D", "ABCD", 3);
    tx(ESC, "ABCD", 3); tx("[", "ABCD", 3); tx("H", "ABCD", 0);
    tx("Z", "ZABC", 1);
    tx("Q", "ZQAB", 2); tx("Q", "ZQQA", 3); tx("Q", "ZQQQ", 3); tx("Q", "ZQQQ", 3);
    line_q.push_back(s2b("ZQQQ"));
    tx(CR, "    ", 0);
    ins_mode = 1'b0;

    // Delete, backspace, end, cursor saturation
    tx("A", "A   ", 1); tx("B", "AB  ", 2); tx("C", "ABC ", 3); tx("D", "ABCD", 3);
    tx(ESC, "ABCD", 3); tx("[", "ABCD", 3); tx("H", "ABCD", 0);
    tx(ESC, "ABCD", 0); tx("[", "ABCD", 0); tx("3", "ABCD", 0); tx("~", "BCD ", 0);
    tx(BS, "BCD ", 0);
    tx(ESC, "BCD ", 0); tx("[", "BCD ", 0); tx("F", "BCD ", 3);
    tx(BS, "BC  ", 2);
    tx(DEL, "B   ", 1);
    tx(ESC, "B   ", 1); tx("[", "B   ", 1); tx("C", "B   ", 2);
    tx(ESC, "B   ", 2); tx("[", "B   ", 2); tx("C", "B   ", 3);
    tx(ESC, "B   ", 3); tx("[", "B   ", 3); tx("C", "B   ", 3);
    tx(ESC, "B   ", 3); tx("[", "B   ", 3); tx("H", "B   ", 0);
    tx(ESC, "B   ", 0); tx("[", "B   ", 0); tx("D", "B   ", 0);

    // Aborted sequences and restarts
    tx(ESC, "B   ", 0); tx_err("x", "B   ", 0);
    tx(ESC, "B   ", 0); tx(ESC, "B   ", 0); tx("[", "B   ", 0); tx("C", "B   ", 1);
    tx(ESC, "B   ", 1); tx("[", "B   ", 1); tx_err("Q", "B   ", 1);
    tx(ESC, "B   ", 1); tx("[", "B   ", 1); tx("3", "B   ", 1); tx_err("A", "B   ", 1);
    tx(ESC, "B   ", 1); tx("[", "B   ", 1); tx_err(CR, "B   ", 1);
    tx(ESC, "B   ", 1); tx("[", "B   ", 1); tx("3", "B   ", 1);
    tx(ESC, "B   ", 1); tx("[", "B   ", 1); tx("C", "B   ", 2);
    tx(8'h01, "B   ", 2);

    // Escape timeout, then 'C' must be a printable
    tx(ESC, "B   ", 2); err_q.push_back(1); tx("[", "B   ", 2);
    k = 0;
    while (!seq_err && k < ESC_TO + 5) begin
      @(posedge clk); #1;
      k++;
    end
    chk("timeout_latency", 64'(k), 64'(ESC_TO));
    tx("C", "B C ", 3);

    // Byte arriving on the expiry cycle wins over the timeout
    tx(ESC, "B C ", 3);
    repeat (ESC_TO - 1) begin @(posedge clk); #1; end
    tx("[", "B C ", 3); tx("D", "B C ", 2);
    line_q.push_back(s2b("B C "));
    tx(CR, "    ", 0);

    // Line hand-off with back-pressure
    tx("H", "H   ", 1); tx("I", "HI  ", 2);
    line_ready = 1'b0;
    line_q.push_back(s2b("HI  "));
    tx(CR, "    ", 0);
    exp_q.push_back('{d: s2b("K   "), c: 2'd1});
    in_data  = "K";
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_line_valid", 64'(line_valid), 64'd1);
      chk("stall_line_data", 64'(line_data), 64'(s2b("HI  ")));
      chk("stall_disp", 64'(disp), 64'(s2b("    ")));
      chk("stall_cursor", 64'(cursor), 64'd0);
      @(posedge clk); #1;
    end
    line_ready = 1'b1;
    #1;
    chk("handshake_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("line_valid_drop", 64'(line_valid), 64'd0);

    // Asynchronous reset mid-CSI
    tx(ESC, "K   ", 1); tx("[", "K   ", 1);
    settle();
    rst = 1'b1;
    #2;
    chk("arst_csi_disp", 64'(disp), 64'(s2b("    ")));
    chk("arst_csi_cursor", 64'(cursor), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    tx("C", "C   ", 1);

    // Asynchronous reset while a line is pending
    line_ready = 1'b0;
    tx(CR, "    ", 0);
    @(posedge clk); #1;
    chk("pend_line_valid", 64'(line_valid), 64'd1);
    chk("pend_line_data", 64'(line_data), 64'(s2b("C   ")));
    settle();
    rst = 1'b1;
    #2;
    chk("arst_line_valid", 64'(line_valid), 64'd0);
    chk("arst_line_data", 64'(line_data), 64'(s2b("    ")));
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); rst = 1'b0; line_ready = 1'b1;
    @(posedge clk); #1;
    tx("C", "C   ", 1);

    repeat (3) @(negedge clk);
    #1;
    chk("byte_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("line_queue_empty", 64'(line_q.size()), 64'd0);
    chk("err_queue_empty", 64'(err_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/term_line_editor.md
Name: term_line_editor

Overview:
- Parametrised line editor for the display terminal. Consumes a byte stream from the UART side: printable ASCII, BS/DEL, CR and ANSI escape sequences (ESC [ C/D/H/F, ESC [ 3 ~).
- Maintains an NPOS-character display buffer and a cursor.
- On Enter, hands the completed line to a downstream consumer over a valid/ready handshake.
- Successor to the fixed 4-position cursor/escape controller: adds configurable width, insert mode, home/end, escape timeout and line output.

Parameters:
- NPOS, 4, number of character positions on the display (>=2)
- ESC_TO, 1023, cycles allowed between bytes of an escape sequence before it is abandoned (>=1)
- CURW, $clog2(NPOS), cursor index width (derived, do not override)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input byte valid
- in_data  in  8  input byte
- in_ready  out  1  byte accepted when in_valid&&in_ready
- ins_mode  in  1  1=insert, 0=overwrite; sampled with each printable byte
- disp  out  8*NPOS  buffer; position i at [8i+7:8i]; position 0 leftmost
- cursor  out  CURW  current cursor position
- line_valid  out  1  completed line available
- line_data  out  8*NPOS  line snapshot, stable while line_valid
- line_ready  in  1  consumer accepts line
- seq_err  out  1  one-cycle pulse when an escape sequence is aborted (bad byte or timeout)

Behaviour:
- Reset: disp all 0x20; cursor=0; state=IDLE; line_valid=0; line_data all 0x20; seq_err=0; timeout counter=0. Asynchronous reset takes effect mid-sequence, mid-edit or mid-handshake alike.
- Throughput: one byte per cycle. An accepted byte updates disp/cursor at the next clock edge (1-cycle latency).
- in_ready=0 only while line_valid=1 && line_ready=0; otherwise 1.
- Parser FSM states: IDLE, ESC, CSI, CSI3.
- IDLE:
  - 0x1B -> ESC.
  - 0x20..0x7E printable:
    - overwrite: disp[cursor]=byte.
    - insert: positions cursor..NPOS-2 shift right by one; last char is dropped; disp[cursor]=byte.
    - Cursor then increments, saturating at NPOS-1. At NPOS-1 further printables keep overwriting (or inserting at) the last position.
  - 0x08 or 0x7F: if cursor>0, cursor-=1, then delete at the new cursor; else no-op.
  - 0x0D: see Enter.
  - All other bytes are ignored.
- Delete at position p: positions p+1..NPOS-1 shift left by one; disp[NPOS-1]=0x20; cursor unchanged.
- ESC:
  - '[' -> CSI.
  - 0x1B -> stay in ESC (restart).
  - Any other byte -> IDLE, seq_err pulse, byte discarded.
- CSI:
  - 'C' -> cursor+1, saturating at NPOS-1.
  - 'D' -> cursor-1, saturating at 0.
  - 'H' -> cursor=0.
  - 'F' -> cursor=NPOS-1.
  - 'C', 'D', 'H', 'F' all return to IDLE.
  - '3' -> CSI3.
  - 0x1B -> ESC.
  - Any other byte -> IDLE, seq_err, discarded.
- CSI3:
  - '~' -> delete at cursor, then IDLE.
  - 0x1B -> ESC.
  - Any other byte -> IDLE, seq_err, discarded.
- Timeout:
  - Counter clears on every accepted byte and increments each cycle while the state is ESC, CSI or CSI3.
  - On reaching ESC_TO: state -> IDLE, seq_err pulses, counter clears.
  - Timeout and an accepted byte in the same cycle: the byte wins; no seq_err.
- Enter (0x0D in IDLE):
  - line_data <= disp, with the current byte's edit excluded.
  - line_valid <= 1; disp cleared to 0x20; cursor=0.
  - line_valid stays 1 until a cycle with line_ready=1, then drops the next cycle.
  - While line_valid=1, line_data is held constant.
  - in_ready is 1 in the cycle where line_ready=1, so a byte may be accepted in the same cycle as the handshake completes.
- Enter received in ESC, CSI or CSI3 counts as a bad byte (abort with seq_err; no line emitted).
- Cursor arithmetic is unsigned CURW bits; wrap-around never occurs (saturating only).

Test Plan:
- NPOS=4, overwrite: send "AB", ESC [ D, "X" -> disp="AX  " (pos0..3), cursor=2.
- NPOS=4, ins_mode=1: "ABCD", ESC [ H, "Z" -> disp="ZABC", cursor=1. Then "QQQQ" -> cursor saturates at 3, disp="ZQQQ".
- "ABCD", ESC [ H, ESC [ 3 ~ -> disp="BCD ", cursor=0. Then BS -> no change. Then ESC [ F, BS -> disp="BC  ", cursor=2.
- Abort cases:
  - ESC, 'x' -> seq_err 1 cycle, disp unchanged.
  - ESC [ then idle for ESC_TO cycles -> seq_err, state IDLE; next 'C' is written as a printable.
- "HI", CR with line_ready=0 for 5 cycles -> line_valid=1, line_data="HI  ", disp all spaces, cursor=0, in_ready=0 during the stall. Raise line_ready -> line_valid falls the next cycle; a byte offered in the same cycle is accepted.
- Assert rst mid-CSI and again while line_valid=1 -> immediate reset values; next 'C' is treated as a printable.
